// File: rtl/acc_pkg.sv
// Shared types and arithmetic helpers for the acc_array accumulator bank.
// Functions work on 64-bit signed values; callers sign-extend in and truncate out.
package acc_pkg;

  typedef enum logic [0:0] {ACC_IDLE, ACC_DRAIN} acc_state_e;

  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Round half toward +inf, arithmetic shift, then clamp to out_w signed bits.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int unsigned        sh,
                                                 input int unsigned        out_w);
    logic signed [63:0] r;
    if (sh == 0) r = acc;
    else         r = (acc + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > sat_max(out_w))      r = sat_max(out_w);
    else if (r < sat_min(out_w)) r = sat_min(out_w);
    return r;
  endfunction

endpackage

// File: rtl/acc_array_if.sv
// Drained-word stream from acc_array: valid/ready with lane index and last marker.
interface acc_array_if #(
  parameter int CH_W  = 2,
  parameter int OUT_W = 8
);
  logic                    vld;
  logic                    rdy;
  logic [CH_W-1:0]         ch;
  logic signed [OUT_W-1:0] data;
  logic                    last;

  modport master (output vld, ch, data, last, input rdy);
  modport slave  (input vld, ch, data, last, output rdy);
endinterface

// File: rtl/acc_lane.sv
// One saturating accumulator lane with sticky saturation flag.
// Update priority: clr > load > add.
module acc_lane
  import acc_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic signed [ACC_W-1:0] load_val,
  input  logic                    add_en,
  input  logic signed [IN_W-1:0]  add_val,
  output logic signed [ACC_W-1:0] acc,
  output logic                    sat
);

  logic signed [ACC_W-1:0] add_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;
  logic                    unf;

  always_comb begin
    add_ext = ACC_W'(add_val);
    sum     = acc + add_ext;
    // Overflow only possible when both operands share a sign the sum lost.
    ovf     = !acc[ACC_W-1] && !add_ext[ACC_W-1] &&  sum[ACC_W-1];
    unf     =  acc[ACC_W-1] &&  add_ext[ACC_W-1] && !sum[ACC_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (load) begin
      acc <= load_val;
      sat <= 1'b0;
    end else if (add_en) begin
      if (ovf) begin
        acc <= ACC_W'(sat_max(ACC_W));
        sat <= 1'b1;
      end else if (unf) begin
        acc <= ACC_W'(sat_min(ACC_W));
        sat <= 1'b1;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: rtl/acc_array.sv
// Multi-lane saturating accumulator bank with a sequential requantising drain.
// Define ACC_ARRAY_AUTO_CLR_EN to clear each lane as it is drained.
module acc_array
  import acc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int SH_W   = $clog2(ACC_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_clr,
  input  logic                    acc_vld,
  input  logic [NUM_CH-1:0]       acc_mask,
  input  logic [NUM_CH*IN_W-1:0]  acc_data,
  input  logic                    load_vld,
  input  logic [NUM_CH*ACC_W-1:0] load_data,
  input  logic                    drain_start,
  input  logic [SH_W-1:0]         drain_shift,
  output logic                    drain_busy,
  acc_array_if.master             out,
  output logic [NUM_CH*ACC_W-1:0] acc_q,
  output logic [NUM_CH-1:0]       acc_sat
);

  acc_state_e              state_q, state_d;
  logic [SH_W-1:0]         shift_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [OUT_W-1:0] data_q;
  logic                    last_q;
  logic signed [ACC_W-1:0] lane_q [NUM_CH];

  logic                    hs;
  logic                    accept;
  logic [CH_W-1:0]         sel_ch;
  logic [SH_W-1:0]         sel_sh;
  logic                    last_d;
  logic signed [OUT_W-1:0] rq_data;

  assign hs     = out.vld & out.rdy;
  assign accept = (state_q == ACC_IDLE) & drain_start & ~acc_clr;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic lane_clr;
`ifdef ACC_ARRAY_AUTO_CLR_EN
    assign lane_clr = acc_clr | (hs & (ch_q == CH_W'(i)));
`else
    assign lane_clr = acc_clr;
`endif
    acc_lane #(.IN_W(IN_W), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (lane_clr),
      .load     (load_vld & ~drain_busy),
      .load_val (load_data[i*ACC_W +: ACC_W]),
      .add_en   (acc_vld & acc_mask[i] & ~drain_busy),
      .add_val  (acc_data[i*IN_W +: IN_W]),
      .acc      (lane_q[i]),
      .sat      (acc_sat[i])
    );
    assign acc_q[i*ACC_W +: ACC_W] = lane_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC_IDLE:  if (accept) state_d = ACC_DRAIN;
      ACC_DRAIN: if (acc_clr || (hs && out.last)) state_d = ACC_IDLE;
      default:   state_d = ACC_IDLE;
    endcase
  end

  always_comb begin
    drain_busy = (state_q == ACC_DRAIN);
    out.vld    = drain_busy;
    out.ch     = ch_q;
    out.data   = data_q;
    out.last   = last_q;
  end

  // Requantiser input: lane 0 with the live shift on start, next lane afterwards.
  always_comb begin
    sel_ch = '0;
    sel_sh = drain_shift;
    if (state_q == ACC_DRAIN) begin
      sel_sh = shift_q;
      if (int'(ch_q) < NUM_CH - 1) sel_ch = ch_q + CH_W'(1);
    end
    last_d  = (sel_ch == CH_W'(NUM_CH - 1));
    rq_data = OUT_W'(requant(64'(lane_q[sel_ch]), 32'(sel_sh), OUT_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      ch_q    <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (accept) begin
      shift_q <= drain_shift;
      ch_q    <= '0;
      data_q  <= rq_data;
      last_q  <= last_d;
    end else if (state_q == ACC_DRAIN) begin
      if (acc_clr || (hs && last_q)) begin
        ch_q   <= '0;
        data_q <= '0;
        last_q <= 1'b0;
      end else if (hs) begin
        ch_q   <= sel_ch;
        data_q <= rq_data;
        last_q <= last_d;
      end
    end
  end

endmodule

// File: tb/tb_acc_array.sv
// Directed self-checking bench for acc_array with hand-computed expectations.
// Honours ACC_ARRAY_AUTO_CLR_EN when it is defined for the build.
module tb_acc_array;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int ACC_W  = 24;
  localparam int OUT_W  = 8;
  localparam int CH_W   = 2;
  localparam int SH_W   = 5;
`ifdef ACC_ARRAY_AUTO_CLR_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    acc_clr = 1'b0;
  logic                    acc_vld = 1'b0;
  logic [NUM_CH-1:0]       acc_mask = '0;
  logic [NUM_CH*IN_W-1:0]  acc_data = '0;
  logic                    load_vld = 1'b0;
  logic [NUM_CH*ACC_W-1:0] load_data = '0;
  logic                    drain_start = 1'b0;
  logic [SH_W-1:0]         drain_shift = '0;
  logic                    drain_busy;
  logic [NUM_CH*ACC_W-1:0] acc_q;
  logic [NUM_CH-1:0]       acc_sat;

  acc_array_if #(.CH_W(CH_W), .OUT_W(OUT_W)) out_if ();

  acc_array #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .ACC_W(ACC_W), .OUT_W(OUT_W), .CH_W(CH_W), .SH_W(SH_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_clr     (acc_clr),
    .acc_vld     (acc_vld),
    .acc_mask    (acc_mask),
    .acc_data    (acc_data),
    .load_vld    (load_vld),
    .load_data   (load_data),
    .drain_start (drain_start),
    .drain_shift (drain_shift),
    .drain_busy  (drain_busy),
    .out         (out_if),
    .acc_q       (acc_q),
    .acc_sat     (acc_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int last_hs = 0;
  logic signed [OUT_W-1:0] exp_out [NUM_CH];

  always @(negedge clk)
    if (rst_n && out_if.vld && out_if.rdy && out_if.last) last_hs++;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic signed [63:0] lane(input int i);
    logic signed [ACC_W-1:0] v;
    v = acc_q[i*ACC_W +: ACC_W];
    return 64'(v);
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_vld"},  64'(out_if.vld), 0);
    chk({tag, "_busy"}, 64'(drain_busy), 0);
    chk({tag, "_ch"},   64'(out_if.ch), 0);
    chk({tag, "_data"}, 64'(out_if.data), 0);
    chk({tag, "_last"}, 64'(out_if.last), 0);
    chk({tag, "_sat"},  64'(acc_sat), 0);
    for (int i = 0; i < NUM_CH; i++) chk($sformatf("%s_lane%0d", tag, i), lane(i), 0);
  endtask

  task automatic check_lanes(input string tag, input int l0, input int l1, input int l2, input int l3);
    chk({tag, "_l0"}, lane(0), 64'(l0));
    chk({tag, "_l1"}, lane(1), 64'(l1));
    chk({tag, "_l2"}, lane(2), 64'(l2));
    chk({tag, "_l3"}, lane(3), 64'(l3));
  endtask

  task automatic load_lanes(input int l0, input int l1, input int l2, input int l3);
    load_data = {24'(l3), 24'(l2), 24'(l1), 24'(l0)};
    load_vld  = 1'b1;
    tick();
    load_vld  = 1'b0;
  endtask

  // Full drain of all lanes; optional stall with accumulate noise on one lane.
  task automatic drain_run(input logic [SH_W-1:0] sh, input int stall_lane, input int stall_n);
    drain_start = 1'b1;
    drain_shift = sh;
    tick();
    drain_start = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("drain_vld%0d", k),  64'(out_if.vld), 1);
      chk($sformatf("drain_ch%0d", k),   64'(out_if.ch), 64'(k));
      chk($sformatf("drain_data%0d", k), 64'(out_if.data), 64'(exp_out[k]));
      chk($sformatf("drain_last%0d", k), 64'(out_if.last), (k == NUM_CH - 1) ? 1 : 0);
      if (k == stall_lane) begin
        for (int s = 0; s < stall_n; s++) begin
          out_if.rdy = 1'b0;
          acc_vld    = 1'b1;
          acc_mask   = '1;
          acc_data   = {4{16'sd7}};
          tick();
          chk($sformatf("stall_data%0d", s), 64'(out_if.data), 64'(exp_out[k]));
          chk($sformatf("stall_ch%0d", s),   64'(out_if.ch), 64'(k));
        end
        acc_vld = 1'b0;
      end
      out_if.rdy = 1'b1;
      tick();
      out_if.rdy = 1'b0;
    end
    chk("drain_end_vld",  64'(out_if.vld), 0);
    chk("drain_end_busy", 64'(drain_busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hs_before;
    out_if.rdy = 1'b0;

    // Reset held with random inputs
    for (int c = 0; c < 4; c++) begin
      acc_clr     = 1'($urandom);
      acc_vld     = 1'($urandom);
      acc_mask    = 4'($urandom);
      acc_data    = {$urandom, $urandom};
      load_vld    = 1'($urandom);
      load_data   = {$urandom, $urandom, $urandom};
      drain_start = 1'($urandom);
      drain_shift = 5'($urandom);
      out_if.rdy  = 1'($urandom);
      tick();
    end
    check_idle("rst");
    acc_clr = 0; acc_vld = 0; acc_mask = '0; acc_data = '0;
    load_vld = 0; load_data = '0; drain_start = 0; drain_shift = '0; out_if.rdy = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check_idle("idle");

    // Masked accumulate
    acc_vld = 1'b1; acc_mask = 4'b0101; acc_data = {4{16'sd5}};
    for (int c = 0; c < 3; c++) tick();
    acc_vld = 1'b0;
    check_lanes("mask", 15, 0, 15, 0);
    chk("mask_sat", 64'(acc_sat), 0);

    // Saturation and sticky flag
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    acc_vld = 1'b1; acc_mask = 4'b0001; acc_data = {48'd0, 16'h7FFF};
    for (int c = 0; c < 300; c++) tick();
    chk("sat_hi", lane(0), 64'sh7FFFFF);
    chk("sat_flag", 64'(acc_sat), 1);
    acc_data = {48'd0, 16'hFFFF};
    tick();
    acc_vld = 1'b0;
    chk("sat_dec", lane(0), 64'sh7FFFFE);
    chk("sat_sticky", 64'(acc_sat), 1);
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    chk("sat_clr_lane", lane(0), 0);
    chk("sat_clr_flag", 64'(acc_sat), 0);

    // Drain with backpressure on lane 1 and accumulate noise
    load_lanes(40, -40, 2000, -24);
    exp_out[0] = 3; exp_out[1] = -2; exp_out[2] = 125; exp_out[3] = -1;
    drain_run(5'd4, 1, 3);
    if (AUTO) check_lanes("post_drain", 0, 0, 0, 0);
    else      check_lanes("post_drain", 40, -40, 2000, -24);

    // Output clamp, then back-to-back drain accepted as busy falls
    load_lanes(1000, -1000, 127, -128);
    exp_out[0] = 127; exp_out[1] = -128; exp_out[2] = 127; exp_out[3] = -128;
    drain_run(5'd0, -1, 0);
    if (AUTO) begin
      exp_out[0] = 0; exp_out[1] = 0; exp_out[2] = 0; exp_out[3] = 0;
    end
    drain_run(5'd0, -1, 0);

    // Abort with acc_clr after lane 1 handshake
    load_lanes(100, 200, 300, 400);
    hs_before = last_hs;
    drain_start = 1'b1; drain_shift = '0; tick(); drain_start = 1'b0;
    chk("abort_vld0", 64'(out_if.vld), 1);
    out_if.rdy = 1'b1;
    tick();
    tick();
    out_if.rdy = 1'b0;
    chk("abort_ch2", 64'(out_if.ch), 2);
    chk("abort_data2", 64'(out_if.data), 127);
    acc_clr = 1'b1; tick(); acc_clr = 1'b0;
    chk("abort_vld", 64'(out_if.vld), 0);
    chk("abort_busy", 64'(drain_busy), 0);
    chk("abort_last", 64'(out_if.last), 0);
    chk("abort_no_last_hs", 64'(last_hs), 64'(hs_before));
    check_lanes("abort", 0, 0, 0, 0);

    // Asynchronous reset in the middle of a drain
    load_lanes(5, 6, 7, 8);
    drain_start = 1'b1; tick(); drain_start = 1'b0;
    chk("arst_pre_vld", 64'(out_if.vld), 1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("arst");
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
